// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: FSM states, access sizes,
// default bus timeout and the alignment rule.
package dmem_access_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Any size with bit 1 set is a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Byte-lane write mask and replicated write data for a store of the given
// size at the given low address bits.
module store_lane_gen
  import dmem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  mask_o,
  output logic [31:0] data_o
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    mask_o = 4'b1111;
    data_o = rs2_i;
    case (size_i)
      SZ_BYTE: begin
        mask_o = 4'b0001 << addr_lo_i;
        data_o = {4{rs2_i[7:0]}};
      end
      SZ_HALF: begin
        mask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        data_o = {2{rs2_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: accepts one load/store from execute, runs a single
// bus transaction with timeout, and hands a registered result to the load unit.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  input  logic        is_store_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  output logic        req_ready_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wr_data_o,
  output logic [3:0]  dm_wr_mask_o,
  output logic        dm_wr_req_o,
  output logic        dm_rd_req_o,
  input  logic        dm_ack_in,
  input  logic [31:0] dm_rd_data_in,
  output logic [31:0] dm_data_o,
  output logic [1:0]  iadder_out_1to0_o,
  output logic [1:0]  load_size_o,
  output logic        load_unsigned_o,
  output logic        load_valid_o,
  output logic        store_done_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             unsigned_q, unsigned_d;
  logic             store_q, store_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [3:0]       wr_mask_q, wr_mask_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [1:0]       out_lo_q, out_lo_d;
  logic [1:0]       out_size_q, out_size_d;
  logic             out_unsigned_q, out_unsigned_d;
  logic             load_valid_q, load_valid_d;
  logic             store_done_q, store_done_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_err_q, bus_err_d;

  logic [3:0]       lane_mask;
  logic [31:0]      lane_data;

  store_lane_gen u_store_lane_gen (
    .size_i    (load_size_in),
    .addr_lo_i (iadder_in[1:0]),
    .rs2_i     (rs2_in),
    .mask_o    (lane_mask),
    .data_o    (lane_data)
  );

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    addr_d         = addr_q;
    size_d         = size_q;
    unsigned_d     = unsigned_q;
    store_d        = store_q;
    wr_data_d      = wr_data_q;
    wr_mask_d      = wr_mask_q;
    rd_data_d      = rd_data_q;
    out_lo_d       = out_lo_q;
    out_size_d     = out_size_q;
    out_unsigned_d = out_unsigned_q;
    load_valid_d   = 1'b0;
    store_done_d   = 1'b0;
    misaligned_d   = 1'b0;
    bus_err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          if (is_misaligned(load_size_in, iadder_in[1:0])) begin
            misaligned_d = 1'b1;
          end else begin
            addr_d     = iadder_in;
            size_d     = load_size_in;
            unsigned_d = load_unsigned_in;
            store_d    = is_store_in;
            wr_mask_d  = is_store_in ? lane_mask : 4'b0000;
            wr_data_d  = is_store_in ? lane_data : 32'd0;
            wait_cnt_d = '0;
            state_d    = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // Ack is tested first so it wins over a simultaneous timeout.
        if (dm_ack_in) begin
          state_d = ST_DONE;
          if (!store_q) begin
            rd_data_d      = dm_rd_data_in;
            out_lo_d       = addr_q[1:0];
            out_size_d     = size_q;
            out_unsigned_d = unsigned_q;
          end
        end else if (wait_cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        load_valid_d = !store_q;
        store_done_d = store_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      addr_q         <= 32'd0;
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      store_q        <= 1'b0;
      wr_data_q      <= 32'd0;
      wr_mask_q      <= 4'b0000;
      rd_data_q      <= 32'd0;
      out_lo_q       <= 2'b00;
      out_size_q     <= 2'b00;
      out_unsigned_q <= 1'b0;
      load_valid_q   <= 1'b0;
      store_done_q   <= 1'b0;
      misaligned_q   <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      unsigned_q     <= unsigned_d;
      store_q        <= store_d;
      wr_data_q      <= wr_data_d;
      wr_mask_q      <= wr_mask_d;
      rd_data_q      <= rd_data_d;
      out_lo_q       <= out_lo_d;
      out_size_q     <= out_size_d;
      out_unsigned_q <= out_unsigned_d;
      load_valid_q   <= load_valid_d;
      store_done_q   <= store_done_d;
      misaligned_q   <= misaligned_d;
      bus_err_q      <= bus_err_d;
    end
  end

  // Bus requests decode from state, so an async reset drops them at once.
  assign req_ready_o       = (state_q == ST_IDLE);
  assign stall_o           = (state_q != ST_IDLE);
  assign dm_rd_req_o       = (state_q == ST_BUS) && !store_q;
  assign dm_wr_req_o       = (state_q == ST_BUS) && store_q;
  assign dm_addr_o         = {addr_q[31:2], 2'b00};
  assign dm_wr_data_o      = wr_data_q;
  assign dm_wr_mask_o      = wr_mask_q;
  assign dm_data_o         = rd_data_q;
  assign iadder_out_1to0_o = out_lo_q;
  assign load_size_o       = out_size_q;
  assign load_unsigned_o   = out_unsigned_q;
  assign load_valid_o      = load_valid_q;
  assign store_done_o      = store_done_q;
  assign misaligned_o      = misaligned_q;
  assign bus_err_o         = bus_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: scoreboard of expected completions,
// immediate-assertion checks sampled on the falling clock edge.
module tb_dmem_access_unit;

  typedef struct {
    logic        is_store;
    logic [31:0] data;
    logic [1:0]  lo;
    logic [1:0]  size;
    logic        uns;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        is_store_in = 1'b0;
  logic [1:0]  load_size_in = 2'b00;
  logic        load_unsigned_in = 1'b0;
  logic [31:0] iadder_in = 32'd0;
  logic [31:0] rs2_in = 32'd0;
  logic        dm_ack_in = 1'b0;
  logic [31:0] dm_rd_data_in = 32'd0;
  logic        req_ready_o, dm_wr_req_o, dm_rd_req_o, load_unsigned_o;
  logic        load_valid_o, store_done_o, stall_o, misaligned_o, bus_err_o;
  logic [31:0] dm_addr_o, dm_wr_data_o, dm_data_o;
  logic [3:0]  dm_wr_mask_o;
  logic [1:0]  iadder_out_1to0_o, load_size_o;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .is_store_in       (is_store_in),
    .load_size_in      (load_size_in),
    .load_unsigned_in  (load_unsigned_in),
    .iadder_in         (iadder_in),
    .rs2_in            (rs2_in),
    .req_ready_o       (req_ready_o),
    .dm_addr_o         (dm_addr_o),
    .dm_wr_data_o      (dm_wr_data_o),
    .dm_wr_mask_o      (dm_wr_mask_o),
    .dm_wr_req_o       (dm_wr_req_o),
    .dm_rd_req_o       (dm_rd_req_o),
    .dm_ack_in         (dm_ack_in),
    .dm_rd_data_in     (dm_rd_data_in),
    .dm_data_o         (dm_data_o),
    .iadder_out_1to0_o (iadder_out_1to0_o),
    .load_size_o       (load_size_o),
    .load_unsigned_o   (load_unsigned_o),
    .load_valid_o      (load_valid_o),
    .store_done_o      (store_done_o),
    .stall_o           (stall_o),
    .misaligned_o      (misaligned_o),
    .bus_err_o         (bus_err_o)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // Drives one request for a single cycle; pushes the expected completion when asked.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] rdata, input bit push);
    exp_t e;
    req_valid_in = 1'b1; is_store_in = st; load_size_in = sz;
    load_unsigned_in = uns; iadder_in = addr; rs2_in = rs2;
    acc_cyc = cyc;
    if (push) begin
      e.is_store = st; e.data = rdata; e.lo = addr[1:0]; e.size = sz; e.uns = uns;
      sb_q.push_back(e);
    end
    tick();
    req_valid_in = 1'b0;
  endtask

  task automatic ack_after(input int waits, input logic [31:0] rdata);
    repeat (waits) tick();
    dm_ack_in = 1'b1; dm_rd_data_in = rdata;
    tick();
    dm_ack_in = 1'b0;
  endtask

  task automatic complete(input string tag, input int exp_lat);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (load_valid_o || store_done_o) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({tag, "_kind"}, {31'd0, store_done_o}, {31'd0, e.is_store});
        check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
        check({tag, "_bus_err"}, {31'd0, bus_err_o}, 32'd0);
        if (!e.is_store) begin
          check({tag, "_data"}, dm_data_o, e.data);
          check({tag, "_lo"}, {30'd0, iadder_out_1to0_o}, {30'd0, e.lo});
          check({tag, "_size"}, {30'd0, load_size_o}, {30'd0, e.size});
          check({tag, "_uns"}, {31'd0, load_unsigned_o}, {31'd0, e.uns});
        end
      end
      tick();
      check({tag, "_pulse_end"}, {30'd0, load_valid_o, store_done_o}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_outs", {stall_o, dm_rd_req_o, dm_wr_req_o, load_valid_o, store_done_o,
                       misaligned_o, bus_err_o, load_unsigned_o}, 32'd0);
    check("rst_addr", dm_addr_o, 32'd0);
    check("rst_data", dm_data_o, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Load byte unsigned at 0x103, zero-wait ack
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 32'hAABB_CCDD, 1'b1);
    check("lb_rd_req", {31'd0, dm_rd_req_o}, 32'd1);
    check("lb_wr_req", {31'd0, dm_wr_req_o}, 32'd0);
    check("lb_addr", dm_addr_o, 32'h0000_0100);
    check("lb_stall", {30'd0, stall_o, req_ready_o}, 32'd2);
    ack_after(0, 32'hAABB_CCDD);
    check("lb_req_drop", {31'd0, dm_rd_req_o}, 32'd0);
    complete("lb", 3);

    // Store half at 0x202, one wait cycle
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_5678, 32'd0, 1'b1);
    check("sh_wr_req", {30'd0, dm_wr_req_o, dm_rd_req_o}, 32'd2);
    check("sh_mask", {28'd0, dm_wr_mask_o}, 32'b1100);
    check("sh_data", dm_wr_data_o, 32'h5678_5678);
    check("sh_addr", dm_addr_o, 32'h0000_0200);
    tick();
    check("sh_hold", {dm_wr_req_o, dm_wr_mask_o, dm_wr_data_o[26:0]},
          {1'b1, 4'b1100, 27'h678_5678});
    ack_after(0, 32'hDEAD_BEEF);
    complete("sh", 4);
    check("sh_data_held", dm_data_o, 32'hAABB_CCDD);

    // Store byte at 0x001
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'd0, 1'b1);
    check("sb_mask", {28'd0, dm_wr_mask_o}, 32'b0010);
    check("sb_data", dm_wr_data_o, 32'hA5A5_A5A5);
    ack_after(0, 32'd0);
    complete("sb", 3);

    // Load word at 0x40, two wait cycles
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'd0, 32'h1122_3344, 1'b1);
    ack_after(2, 32'h1122_3344);
    complete("lw", 5);

    // Ack outside BUS is ignored
    dm_ack_in = 1'b1; dm_rd_data_in = 32'hFFFF_FFFF;
    tick();
    dm_ack_in = 1'b0;
    check("idle_ack", {29'd0, load_valid_o, store_done_o, req_ready_o}, 32'd1);
    check("idle_ack_data", dm_data_o, 32'h1122_3344);

    // Misaligned word at 0x301, then misaligned half at 0x011
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'd0, 32'd0, 1'b0);
    check("mis_w_pulse", {29'd0, misaligned_o, dm_rd_req_o, req_ready_o}, 32'b101);
    tick();
    check("mis_w_end", {29'd0, misaligned_o, dm_rd_req_o, req_ready_o}, 32'b001);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'd0, 32'd0, 1'b0);
    check("mis_h_pulse", {29'd0, misaligned_o, dm_wr_req_o, req_ready_o}, 32'b101);
    tick();

    // Timeout: no ack; a request arriving during BUS is ignored
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0, 32'd0, 1'b0);
    req_valid_in = 1'b1; is_store_in = 1'b1; iadder_in = 32'h0000_0900;
    tick();
    req_valid_in = 1'b0;
    check("busy_ignore", {dm_addr_o[30:0], dm_wr_req_o}, {31'h0000_0500, 1'b0});
    tick(); tick();
    check("to_4th_cycle", {29'd0, dm_rd_req_o, bus_err_o, load_valid_o}, 32'b100);
    tick();
    check("to_err", {28'd0, bus_err_o, dm_rd_req_o, req_ready_o, load_valid_o}, 32'b1010);
    tick();
    check("to_err_end", {29'd0, bus_err_o, load_valid_o, req_ready_o}, 32'b001);
    check("to_data_held", dm_data_o, 32'h1122_3344);

    // Ack in the timeout cycle wins
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0602, 32'd0, 32'hCAFE_F00D, 1'b1);
    ack_after(3, 32'hCAFE_F00D);
    check("race_no_err", {30'd0, bus_err_o, stall_o}, 32'b01);
    complete("race", 6);

    // Reset mid-BUS after two wait cycles
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0700, 32'h0000_0055, 32'd0, 1'b0);
    tick(); tick();
    check("rst_pre", {31'd0, dm_wr_req_o}, 32'd1);
    #2 rst_in = 1'b1;
    #1;
    check("rst_async_req", {29'd0, dm_wr_req_o, dm_rd_req_o, req_ready_o}, 32'b001);
    check("rst_async_mask", {28'd0, dm_wr_mask_o}, 32'd0);
    tick(); tick();
    check("rst_no_pulse", {29'd0, load_valid_o, store_done_o, bus_err_o}, 32'd0);
    rst_in = 1'b0;
    tick();
    check("rst_release", {28'd0, req_ready_o, load_valid_o, store_done_o, bus_err_o}, 32'b1000);
    check("rst_data_clr", dm_data_o, 32'd0);

    // Signed half load at 0x12 after reset
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0, 32'h8001_0000, 1'b1);
    check("lh_addr", dm_addr_o, 32'h0000_0010);
    ack_after(0, 32'h8001_0000);
    complete("lh", 3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of BUS-state cycles without ack before a bus error is declared.
REQ-002 SHALL have port clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_in, input, 1: a memory request from execute is present.
REQ-005 SHALL have port is_store_in, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port load_size_in, input, 2: access size; 00 byte, 01 half, 1x word; applies to stores too.
REQ-007 SHALL have port load_unsigned_in, input, 1: zero-extend flag, forwarded unchanged.
REQ-008 SHALL have port iadder_in, input, 32: effective byte address.
REQ-009 SHALL have port rs2_in, input, 32: store data.
REQ-010 SHALL have port req_ready_o, output, 1: the unit can accept a request (IDLE).
REQ-011 SHALL have ports dm_addr_o (output, 32), dm_wr_data_o (output, 32), dm_wr_mask_o (output, 4), dm_wr_req_o (output, 1), dm_rd_req_o (output, 1): data-memory bus signals.
REQ-012 SHALL have ports dm_ack_in (input, 1) and dm_rd_data_in (input, 32): memory completion and read word.
REQ-013 SHALL have ports dm_data_o (output, 32), iadder_out_1to0_o (output, 2), load_size_o (output, 2), load_unsigned_o (output, 1): registered payload for the downstream load unit.
REQ-014 SHALL have port load_valid_o, output, 1: dm_data_o is valid.
REQ-015 SHALL have port store_done_o, output, 1: a store has completed.
REQ-016 SHALL have ports stall_o (output, 1), misaligned_o (output, 1), bus_err_o (output, 1): pipeline stall and error pulses.

Function
REQ-017 SHALL implement the FSM states IDLE, BUS and DONE; req_ready_o = (state==IDLE); stall_o = (state!=IDLE).
REQ-018 SHALL treat a request as misaligned when half with iadder_in[0]=1, or word with iadder_in[1:0]!=00.
REQ-019 SHALL, in IDLE on a misaligned request, pulse misaligned_o for one cycle, stay in IDLE and issue no bus request.
REQ-020 SHALL, in IDLE on an aligned request, latch address, size, unsigned flag, store flag and store lanes, clear the wait counter and enter BUS next cycle.
REQ-021 SHALL, in BUS, hold dm_rd_req_o=1 (load) or dm_wr_req_o=1 (store) and keep all bus outputs stable until ack.
REQ-022 SHALL drive dm_addr_o = {addr[31:2],2'b00}.
REQ-023 SHALL generate store lanes as: byte mask 0001<<addr[1:0], data {4{rs2[7:0]}}; half mask 0011<<{addr[1],0}, data {2{rs2[15:0]}}; word mask 1111, data rs2.
REQ-024 SHALL, on dm_ack_in in BUS, drop the request the same edge, capture dm_rd_data_in into dm_data_o for a load, and enter DONE.
REQ-025 SHALL increment the wait counter each BUS cycle without ack; when the counter reaches TIMEOUT_CYCLES-1 without ack, SHALL pulse bus_err_o for one cycle, drop the request and return to IDLE.
REQ-026 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-027 SHALL, in DONE, assert load_valid_o (load) or store_done_o (store) for exactly one cycle, then return to IDLE.
REQ-028 SHALL hold dm_data_o, iadder_out_1to0_o, load_size_o and load_unsigned_o until the next captured load.
REQ-029 SHALL give a minimum load latency of 3 cycles from acceptance to load_valid_o with zero-wait ack; each extra wait cycle adds one.
REQ-030 SHALL ignore dm_ack_in outside BUS and req_valid_in outside IDLE.

Reset
REQ-031 SHALL, on rst_in, asynchronously set state to IDLE, clear the wait counter and latched fields, and drive all outputs to 0 except req_ready_o=1.
REQ-032 SHALL, on reset during BUS, deassert bus requests immediately and produce no load_valid_o, store_done_o or bus_err_o.

Structure
REQ-033 SHALL place the state encoding, the size encodings (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10) and the default TIMEOUT_CYCLES in a shared package.
REQ-034 SHALL implement lane/mask generation as the combinational sub-module store_lane_gen.

Verification
REQ-035 SHALL verify: load byte unsigned at 0x103, memory returns 0xAABBCCDD with 0-wait ack -> load_valid_o 3 cycles after acceptance, dm_data_o=0xAABBCCDD, iadder_out_1to0_o=11, dm_addr_o=0x100.
REQ-036 SHALL verify: store half at 0x202, rs2=0x12345678 -> dm_wr_mask_o=1100, dm_wr_data_o=0x56785678, dm_addr_o=0x200, store_done_o pulse.
REQ-037 SHALL verify: load word at 0x301 -> misaligned_o one-cycle pulse, no dm_rd_req_o, req_ready_o stays 1.
REQ-038 SHALL verify: load with no ack, TIMEOUT_CYCLES=4 -> bus_err_o after 4 BUS cycles, return to IDLE, no load_valid_o.
REQ-039 SHALL verify: ack and timeout in the same cycle -> completion, no bus_err_o.
REQ-040 SHALL verify: rst_in asserted mid-BUS with 2 wait cycles -> requests drop asynchronously, no load_valid_o or store_done_o pulse, IDLE after release.
